psum_drain: RTL
===============

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter: PSUM_W, 24, signed partial-sum width from the PE chain.
REQ-002 Parameter: OUT_W, 8, signed requantized output width.
REQ-003 Parameter: DEPTH, 4, output FIFO depth; power of 2, minimum 2.
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: in_valid  input  1  partial-sum beat present.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: in_psum  input  PSUM_W  signed partial sum (c_out of last PE).
REQ-009 Port: in_last  input  1  final beat of the frame.
REQ-010 Port: shift  input  5  right-shift amount; sampled on the first beat of a frame.
REQ-011 Port: relu_en  input  1  ReLU enable; sampled with shift.
REQ-012 Port: out_valid  output  1  output beat present.
REQ-013 Port: out_ready  input  1  downstream accepts the beat.
REQ-014 Port: out_data  output  OUT_W  signed requantized value.
REQ-015 Port: out_last  output  1  marks the output beat that came from in_last.
REQ-016 Port: sat_cnt  output  16  saturated beats in the current or most recent frame.
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 Transfers: input beat accepted when in_valid && in_ready; output beat consumed when out_valid && out_ready.
REQ-019 FSM states: IDLE, STREAM, DRAIN.
REQ-020 IDLE -> STREAM on an accepted beat with in_last=0. IDLE -> DRAIN on an accepted beat with in_last=1.
REQ-021 STREAM -> DRAIN on an accepted beat with in_last=1.
REQ-022 DRAIN -> IDLE in the cycle the out_last beat is consumed.
REQ-023 in_ready = (state != DRAIN) && (fifo count < DEPTH); a pop in the same cycle does not free a slot for that cycle's push.
REQ-024 shift and relu_en are latched on the first accepted beat in IDLE. That beat uses the live values; later beats of the frame use the latched values.
REQ-025 A shift value above 23 is treated as 23.
REQ-026 Requantization is computed in PSUM_W+1 bits: r = (psum + (s>0 ? 2^(s-1) : 0)) >>> s, with arithmetic shift (round half up).
REQ-027 ReLU: when enabled and r < 0, r = 0.
REQ-028 Saturation: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A beat is saturated when clamping changes its value.
REQ-029 The requantized value and in_last are written to the FIFO on the accept edge.
REQ-030 Latency: out_valid rises in the cycle after the accept edge when the FIFO was empty (1-cycle latency).
REQ-031 FIFO order is strict; out_data and out_last are stable while out_valid && !out_ready.
REQ-032 Simultaneous push and pop with count < DEPTH leaves count unchanged; read and write pointers wrap modulo DEPTH.
REQ-033 sat_cnt clears to 0 on the first accepted beat of a frame. If that beat saturates, sat_cnt becomes 1.
REQ-034 sat_cnt increments by 1 per saturated beat and holds at 16'hFFFF.
REQ-035 sat_cnt holds its value after the frame completes.

Reset
REQ-036 On rst_n=0, immediately and regardless of clk: state=IDLE; FIFO emptied; out_valid=0, out_data=0, out_last=0; sat_cnt=0; busy=0; latched shift=0; latched relu_en=0.
REQ-037 in_ready=1 from the first clock after rst_n deasserts.
REQ-038 Reset mid-frame discards all buffered beats, and no out_last is produced for the aborted frame.

Verification
REQ-039 Single-beat frame: psum=5655, in_last=1, shift=6, relu_en=0 -> next cycle out_valid=1, out_data=88, out_last=1, sat_cnt=0; busy drops after the pop.
REQ-040 Negative value and ReLU: psum=-5612, shift=6, relu_en=0 -> out_data=-88. Same beat with relu_en=1 -> out_data=0.
REQ-041 Saturation: psum=5655, shift=5 -> out_data=127, sat_cnt=1. Next frame psum=-100000, shift=0 -> out_data=-128, sat_cnt=1 (cleared, then incremented).
REQ-042 Backpressure: out_ready=0 with 6 beats offered -> exactly 4 accepted and in_ready=0. Then out_ready=1 -> all 4 emerge in order and the remaining 2 are accepted.
REQ-043 Drain lockout: in_last accepted with 3 beats still buffered -> in_ready=0 until out_last is consumed; a new frame is accepted in the following cycle.
REQ-044 Async reset: rst_n pulsed low mid-frame with 3 beats buffered -> out_valid=0, busy=0, sat_cnt=0 before the next clk edge; no stale beats appear afterwards.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain: requantizes a PE-chain partial-sum stream into OUT_W-bit values through a small output FIFO
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       partial-sum input handshake
//     in_psum, in_last        signed partial sum and frame-end marker
//     shift, relu_en          requant controls, captured on a frame's first beat
//     out_valid/out_ready     output handshake
//     out_data, out_last      requantized value and frame-end marker
//     sat_cnt                 saturated beats in the current or most recent frame
//     busy                    frame in progress (not IDLE)
module psum_drain #(
    parameter int PSUM_W = 24,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] in_psum,
    input  logic                     in_last,
    input  logic        [4:0]        shift,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic        [15:0]       sat_cnt,
    output logic                     busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [PSUM_W:0] MAXV = (PSUM_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [PSUM_W:0] MINV = (PSUM_W+1)'(-(2**(OUT_W-1)));

    logic [1:0]              state;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic signed [OUT_W-1:0] mem_data [DEPTH];
    logic                    mem_last [DEPTH];

    logic                    push, pop, sat, relu_sel;
    logic [4:0]              sh_sel, sh;
    logic signed [PSUM_W:0]  ext, rnd, sum, r, r_relu, q;

    assign in_ready  = (state != DRAIN) && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);
    // Gate with out_valid so the outputs read zero whenever the FIFO is empty.
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_last  = out_valid && mem_last[rd_ptr];

    // The first beat of a frame uses the live controls; later beats use the latched copy.
    always_comb begin
        sh_sel   = (state == IDLE) ? shift : shift_q;
        relu_sel = (state == IDLE) ? relu_en : relu_q;
        sh       = (sh_sel > 5'd23) ? 5'd23 : sh_sel;
        ext      = {in_psum[PSUM_W-1], in_psum};
        rnd      = (sh == 5'd0) ? '0 : ((PSUM_W+1)'(1) << (sh - 5'd1));
        sum      = ext + rnd;
        r        = sum >>> sh;
        r_relu   = (relu_sel && r < 0) ? '0 : r;
        q        = (r_relu > MAXV) ? MAXV : (r_relu < MINV) ? MINV : r_relu;
        sat      = (q != r_relu);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            relu_q  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            sat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state == IDLE) begin
                    shift_q <= shift;
                    relu_q  <= relu_en;
                    sat_cnt <= sat ? 16'd1 : 16'd0;
                    state   <= in_last ? DRAIN : STREAM;
                end else begin
                    if (sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
                    if (in_last) state <= DRAIN;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (state == DRAIN && out_last) state <= IDLE;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= q[OUT_W-1:0];
            mem_last[wr_ptr] <= in_last;
        end
    end
endmodule
